// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial slice adder controller.
//   state_e   : 2-bit FSM encoding (IDLE / RUN / DONE)
//   WIDTH_DEF : default operand width
//   SLICE_DEF : default bits added per cycle
//   num_slices / idx_w : slice count and index-counter width helpers
package serial_add_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int SLICE_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int num_slices(int width, int slice);
        return width / slice;
    endfunction

    // A single-slice configuration still gets a 1-bit counter.
    function automatic int idx_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/slice_adder.sv
// Combinational W-bit ripple-carry adder built from full adders.
//   x, y : W-bit addends
//   ci   : carry in
//   s    : W-bit sum
//   co   : carry out of the top bit
module slice_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
    end

    assign co = c[W];

endmodule

// File: rtl/serial_add_ctrl.sv
// Serial add/subtract controller: runs one SLICE-bit adder over WIDTH-bit
// operands, LSB slice first, one slice per clock, carry registered between
// slices. WIDTH must be a multiple of SLICE.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   a, b, cin, sub      : operands; sub=1 computes a-b and ignores cin
//   out_valid/out_ready : result handshake, result held until accepted
//   sum, cout           : result and carry out of the MSB slice
//   busy                : high in RUN or DONE
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int N     = num_slices(WIDTH, SLICE);
    localparam int IDX_W = idx_w(N);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic [SLICE-1:0]  slice_x, slice_y, slice_s;
    logic              slice_co;

    assign slice_x = a_q[idx_q*SLICE +: SLICE];
    assign slice_y = b_q[idx_q*SLICE +: SLICE];

    slice_adder #(.W(SLICE)) u_slice (
        .x  (slice_x),
        .y  (slice_y),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtract as a + ~b + 1: invert b here, inject the +1
                    // through the initial carry.
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int k = 0; k < N; k++) begin
                    if (idx_q == IDX_W'(k)) sum_d[k*SLICE +: SLICE] = slice_s;
                end
                carry_d = slice_co;
                if (idx_q == IDX_W'(N-1)) begin
                    cout_d  = slice_co;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        cin, sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;

    int checks = 0;
    int errs   = 0;

    serial_add_ctrl #(.WIDTH(16), .SLICE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation with latency and handshake checks.
    task automatic do_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                         input logic icin, input logic isub,
                         input logic [15:0] esum, input logic ecout);
        a = ia; b = ib; cin = icin; sub = isub; in_valid = 1'b1; out_ready = 1'b0;
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        tick();                                   // accepting edge
        in_valid = 1'b0;
        a = ~ia; b = ~ib; cin = ~icin;            // must not matter after accept
        chk({tag, " busy"}, 32'(busy), 32'd1);
        tick(); tick(); tick();
        chk({tag, " early out_valid"}, 32'(out_valid), 32'd0);
        tick();                                   // 4th edge after accept
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " sum"}, 32'(sum), 32'(esum));
        chk({tag, " cout"}, 32'(cout), 32'(ecout));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " back to idle"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        logic [15:0] ra, rb, xa, xb;
        logic        rcin, rsub;
        logic [16:0] model;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("reset in_ready",  32'(in_ready),  32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset busy",      32'(busy),      32'd0);
        chk("reset sum",       32'(sum),       32'd0);
        chk("reset cout",      32'(cout),      32'd0);

        do_op("add1234", 16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0);
        do_op("addFFFF", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        do_op("cinFFFF", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
        do_op("sub5-7",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        do_op("sub7-5",  16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);

        // Backpressure: result held, new operands ignored while in DONE.
        a = 16'h0F0F; b = 16'h00F1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        a = 16'hAAAA; b = 16'h5555;
        tick(); tick(); tick(); tick();
        for (int i = 0; i < 3; i++) begin
            chk("bp out_valid", 32'(out_valid), 32'd1);
            chk("bp sum",       32'(sum),       32'h1000);
            chk("bp cout",      32'(cout),      32'd0);
            chk("bp in_ready",  32'(in_ready),  32'd0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp release", {30'd0, out_valid, in_ready}, 32'b01);

        // Reset at the 2nd RUN edge abandons the op.
        a = 16'h1234; b = 16'h4321; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready",  32'(in_ready),  32'd1);
        chk("rst sum",       32'(sum),       32'd0);
        tick(); tick(); tick(); tick();
        chk("rst no result", 32'(out_valid), 32'd0);
        do_op("after rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0);

        // Back-to-back with in_valid and out_ready held high; operands
        // scrambled mid-RUN. Expected from a plain 17-bit add model.
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rcin = 1'($urandom); rsub = 1'($urandom);
            if (k == 0) begin ra = 16'h8000; rb = 16'h8000; rsub = 1'b0; rcin = 1'b1; end
            xa = rsub ? ~rb : rb;
            model = {1'b0, ra} + {1'b0, xa} + 17'(rsub ? 1'b1 : rcin);
            a = ra; b = rb; cin = rcin; sub = rsub; in_valid = 1'b1;
            chk("b2b in_ready", 32'(in_ready), 32'd1);
            tick();
            a = 16'($urandom); b = 16'($urandom); cin = ~rcin; sub = ~rsub;
            tick();
            xb = 16'($urandom); a = xb; b = ~xb;
            tick(); tick();
            chk("b2b early", 32'(out_valid), 32'd0);
            tick();
            chk("b2b out_valid", 32'(out_valid), 32'd1);
            chk("b2b sum",       32'(sum),       32'(model[15:0]));
            chk("b2b cout",      32'(cout),      32'(model[16]));
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule
